// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M/RV64M multiply/divide unit, one bit per cycle.
//
// Computes all eight M-extension operations. MUL* ops use a 2*XLEN-bit
// shift-add on operand magnitudes. DIV*/REM* ops use restoring
// shift-subtract. Divide-by-zero and signed overflow finish straight away.
// The sign is applied in a single FIX cycle before the result is registered.
//
// Ports
//   clk     in            clock, rising edge
//   rst     in            synchronous active-high reset
//   start   in            request, accepted only while busy=0
//   kill    in            synchronous flush of any in-flight operation
//   funct3  in  [2:0]     000 MUL 001 MULH 010 MULHSU 011 MULHU
//                         100 DIV 101 DIVU 110 REM    111 REMU
//   a       in  [XLEN-1]  rs1 operand, sampled with start
//   b       in  [XLEN-1]  rs2 operand, sampled with start
//   busy    out           high in CALC and FIX
//   valid   out           one-cycle pulse when q holds a new result
//   q       out [XLEN-1]  result, held until the next valid
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] q
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_INIT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      op_q;
  logic            neg_q;      // sign of product / quotient
  logic            rem_neg_q;  // remainder follows the dividend's sign
  logic [XLEN-1:0] hi_q;       // product high half / partial remainder
  logic [XLEN-1:0] lo_q;       // multiplier then product low / dividend then quotient
  logic [XLEN-1:0] mc_q;       // multiplicand or divisor magnitude
  logic            busy_q;
  logic            valid_q;
  logic [XLEN-1:0] q_q;

  // Request decode and operand magnitudes
  logic            is_div;
  logic            a_signed, b_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_q;

  // Per-cycle datapath and sign fix-up
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;
  logic [XLEN-1:0]   result_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    is_div    = funct3[2];
    a_signed  = 1'b0;
    b_signed  = 1'b0;
    special_q = '0;
    if (is_div) begin
      a_signed = ~funct3[0];
      b_signed = ~funct3[0];
    end else begin
      a_signed = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
      b_signed = (funct3[1:0] == 2'b01);
    end
    a_neg    = a_signed & a[XLEN-1];
    b_neg    = b_signed & b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = is_div && (b == '0);
    div_ovf  = is_div && !funct3[0] && (a == INT_MIN) && (b == '1);
    if (div_zero)     special_q = funct3[1] ? a : '1;
    else if (div_ovf) special_q = funct3[1] ? '0 : a;
  end

  always_comb begin
    // Shift-add: add the multiplicand when the current multiplier bit is set,
    // then shift {carry, hi, lo} right by one; the carry fills hi's MSB.
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : '0);
    // Restoring divide: the shifted remainder needs XLEN+1 bits because the
    // previous remainder can be as large as divisor-1 < 2^XLEN.
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, mc_q};
    div_diff  = div_shift[XLEN-1:0] - mc_q;

    prod   = {hi_q, lo_q};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -lo_q : lo_q;
    rem_s  = rem_neg_q ? -hi_q : hi_q;

    result_d = '0;
    case (op_q)
      3'b000:                 result_d = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result_d = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result_d = quo_s;
      default:                result_d = rem_s;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, and reset is
  // sampled synchronously inside the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      mc_q      <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      q_q       <= '0;
    end else if (kill) begin
      // Flush drops any work and any same-cycle start; q keeps its old value.
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
          if (start) begin
            op_q      <= funct3;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            if (div_zero || div_ovf) begin
              q_q     <= special_q;
              valid_q <= 1'b1;
              state_q <= DONE;
            end else begin
              hi_q    <= '0;
              lo_q    <= is_div ? a_mag : b_mag;
              mc_q    <= is_div ? b_mag : a_mag;
              cnt_q   <= CNT_INIT;
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (op_q[2]) begin
            hi_q <= div_ge ? div_diff : div_shift[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], div_ge};
          end else begin
            hi_q <= mul_sum[XLEN:1];
            lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
          end
          if (cnt_q == '0) state_q <= FIX;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        FIX: begin
          q_q     <= result_d;
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign q     = q_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq (XLEN=32 and XLEN=8).
// The stimulus pushes the expected result and its arrival cycle.
// Monitors pop and compare on every valid pulse.
module tb_muldiv_seq;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  typedef struct {
    logic [31:0] q;
    int          cyc;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, kill = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy, valid;
  logic [31:0] q;

  logic        start8 = 1'b0, kill8 = 1'b0;
  logic [2:0]  funct3_8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, valid8;
  logic [7:0]  q8;

  exp_t        sb[$];
  exp_t        sb8[$];
  exp_t        mon_e, mon_e8;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] last_q = '0;

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
    .a(a), .b(b), .busy(busy), .valid(valid), .q(q)
  );

  muldiv_seq #(.XLEN(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .kill(kill8), .funct3(funct3_8),
    .a(a8), .b(b8), .busy(busy8), .valid(valid8), .q(q8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit w8, input logic [31:0] v, input int at, input string tag);
    exp_t e;
    e.q = v;
    e.cyc = at;
    e.tag = tag;
    if (w8) sb8.push_back(e);
    else    sb.push_back(e);
  endtask

  // Called at a falling edge with the DUT idle. Drives start in that cycle
  // (cycle 0), checks the busy profile, and returns at the falling edge of
  // the result cycle.
  task automatic op(input bit w8, input logic [2:0] f3, input logic [31:0] av,
                    input logic [31:0] bv, input logic [31:0] exp_v,
                    input int lat, input string tag);
    int bad = 0;
    if (w8) begin
      start8 = 1'b1; funct3_8 = f3; a8 = av[7:0]; b8 = bv[7:0];
    end else begin
      start = 1'b1; funct3 = f3; a = av; b = bv;
    end
    push(w8, exp_v, cyc + lat, tag);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start  = 1'b0;
        start8 = 1'b0;
      end
      if ((w8 ? busy8 : busy) !== (i < lat)) bad++;
    end
    check({tag, "_busy"}, 64'(bad), 64'd0);
    if (!w8) last_q = exp_v;
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (!rst && valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_valid32: got valid with q=0x%0h, expected no result (cycle %0d)", q, cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_q"}, 64'(q), 64'(mon_e.q));
        check({mon_e.tag, "_cycle"}, 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && valid8) begin
      if (sb8.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_valid8: got valid with q=0x%0h, expected no result (cycle %0d)", q8, cyc);
      end else begin
        mon_e8 = sb8.pop_front();
        check({mon_e8.tag, "_q"}, 64'(q8), 64'(mon_e8.q));
        check({mon_e8.tag, "_cycle"}, 64'(cyc), 64'(mon_e8.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int bad;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_q",     64'(q),     64'd0);
    rst = 1'b0;

    // Multiply family
    @(negedge clk); op(0, MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul");
    @(negedge clk); op(0, MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh");
    @(negedge clk); op(0, MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu");
    @(negedge clk); op(0, MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu");

    // Divide signs and boundaries
    @(negedge clk); op(0, DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, "div_neg");
    @(negedge clk); op(0, REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, "rem_neg");
    @(negedge clk); op(0, DIVU, 32'd100,       32'd7,         32'd14,        34, "divu");
    @(negedge clk); op(0, REMU, 32'd100,       32'd7,         32'd2,         34, "remu");
    @(negedge clk); op(0, REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         34, "rem_negdiv");
    @(negedge clk); op(0, DIV,  32'h8000_0000, 32'd2,         32'hC000_0000, 34, "div_min");
    @(negedge clk); op(0, DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 34, "divu_max");

    // Special cases
    @(negedge clk); op(0, DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1, "div_by0");
    @(negedge clk); op(0, REMU, 32'd5,         32'd0,         32'd5,         1, "remu_by0");
    @(negedge clk); op(0, DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    @(negedge clk); op(0, REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, "rem_ovf");

    // Kill in cycle 10; restart in cycle 11
    @(negedge clk);
    c = cyc;
    start = 1'b1; funct3 = DIVU; a = 32'd100; b = 32'd7;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1)  start = 1'b0;
      if (i == 10) kill = 1'b1;
    end
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy",   64'(busy), 64'd0);
    check("kill_q_held", 64'(q),    64'(last_q));
    check("kill_cycle",  64'(cyc),  64'(c + 11));
    op(0, REMU, 32'd100, 32'd7, 32'd2, 34, "after_kill");

    // Reset in cycle 10; q clears
    @(negedge clk);
    start = 1'b1; funct3 = DIV; a = 32'hFFFF_FFF9; b = 32'd2;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1)  start = 1'b0;
      if (i == 10) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_q",    64'(q),    64'd0);
    op(0, MULHU, 32'h0001_0000, 32'h0001_0000, 32'd1, 34, "after_rst");

    // start held high: accepted in cycles 0 and 34 only
    @(negedge clk);
    c = cyc;
    bad = 0;
    start = 1'b1; funct3 = MUL; a = 32'h1234_5678; b = 32'h10;
    push(0, 32'h2345_6780, c + 34, "b2b_first");
    for (int i = 1; i <= 68; i++) begin
      @(negedge clk);
      if (i == 34) begin
        funct3 = DIVU; a = 32'd1000; b = 32'd10;
        push(0, 32'd100, c + 68, "b2b_second");
      end else if (i == 68) begin
        start = 1'b0;
      end else begin
        funct3 = 3'($urandom);
        a = $urandom;
        b = $urandom;
      end
      if (busy !== ((i != 34) && (i != 68))) bad++;
    end
    check("b2b_busy", 64'(bad), 64'd0);
    last_q = 32'd100;

    // XLEN=8 instance
    @(negedge clk); op(1, DIVU, 32'd200,  32'd3,    32'd66,   10, "x8_divu");
    @(negedge clk); op(1, MUL,  32'h0F,   32'h11,   32'hFF,   10, "x8_mul");
    @(negedge clk); op(1, DIV,  32'h80,   32'hFF,   32'h80,   1,  "x8_div_ovf");

    repeat (5) @(negedge clk);
    check("pending32", 64'(sb.size()),  64'd0);
    check("pending8",  64'(sb8.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
